// File: rtl/umi_host_agent.sv
// rtl/umi_host_agent.sv - UMI host test agent: writes a seeded pattern, reads it back, counts mismatches
// Optional feature macro: UMI_HOST_AGENT_POSTED_EN (posted writes, no write responses)
module umi_host_agent #(
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 256,
    parameter int NW = 16
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          start,
    input  logic [NW-1:0] count,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] host_addr,
    input  logic [63:0]   pattern,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] err_count,
    output logic          uhost_req_valid,
    input  logic          uhost_req_ready,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_resp_valid,
    output logic          uhost_resp_ready,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

    localparam logic [4:0] REQ_RD  = 5'h01;
    localparam logic [4:0] RESP_RD = 5'h02;
    localparam logic [4:0] RESP_WR = 5'h04;
`ifdef UMI_HOST_AGENT_POSTED_EN
    localparam logic [4:0] WR_OPC  = 5'h05;
`else
    localparam logic [4:0] WR_OPC  = 5'h03;
`endif

    state_t        state;
    logic [NW-1:0] index;
    logic [NW-1:0] cnt_q;
    logic [AW-1:0] base_q;
    logic [AW-1:0] host_q;
    logic [63:0]   pat_q;

    logic          req_hs;
    logic          resp_hs;
    logic          last;
    logic [NW-1:0] next_index;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] next_addr;
    logic [4:0]    exp_opc;
    logic          resp_bad;
    logic          err_inc;
    logic          unused_resp;

    function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] base, input logic [NW-1:0] idx);
        return base + (AW'(idx) << 3);
    endfunction

    // Zero-extends or truncates an address to the 64-bit data lane.
    function automatic logic [63:0] low64(input logic [AW-1:0] a);
        logic [AW+63:0] w;
        w = {64'd0, a};
        return w[63:0];
    endfunction

    function automatic logic [CW-1:0] make_cmd(input logic [4:0] opc);
        logic [CW-1:0] c;
        c      = '0;
        c[7:5] = 3'd3;
        c[4:0] = opc;
        return c;
    endfunction

    function automatic logic [DW-1:0] make_data(input logic [63:0] pat, input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d       = '0;
        d[63:0] = pat ^ low64(a);
        return d;
    endfunction

    assign req_hs      = uhost_req_valid & uhost_req_ready;
    assign resp_hs     = uhost_resp_valid & uhost_resp_ready;
    assign last        = (index == cnt_q - NW'(1));
    assign next_index  = index + NW'(1);
    assign cur_addr    = word_addr(base_q, index);
    assign next_addr   = word_addr(base_q, next_index);
    assign unused_resp = ^{uhost_resp_srcaddr, uhost_resp_cmd[CW-1:5], uhost_resp_data[DW-1:64]};

    always_comb begin
        exp_opc  = (state == RD_RESP) ? RESP_RD : RESP_WR;
        resp_bad = (uhost_resp_cmd[4:0] != exp_opc) || (uhost_resp_dstaddr != host_q);
        if (state == RD_RESP && uhost_resp_data[63:0] != (pat_q ^ low64(cur_addr))) begin
            resp_bad = 1'b1;
        end
        err_inc = resp_bad && (err_count != '1);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state             <= IDLE;
            index             <= '0;
            cnt_q             <= '0;
            base_q            <= '0;
            host_q            <= '0;
            pat_q             <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err_count         <= '0;
            uhost_req_valid   <= 1'b0;
            uhost_resp_ready  <= 1'b0;
            uhost_req_cmd     <= '0;
            uhost_req_dstaddr <= '0;
            uhost_req_srcaddr <= '0;
            uhost_req_data    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count <= '0;
                        if (count != '0) begin
                            cnt_q             <= count;
                            base_q            <= base_addr;
                            host_q            <= host_addr;
                            pat_q             <= pattern;
                            index             <= '0;
                            done              <= 1'b0;
                            busy              <= 1'b1;
                            state             <= WR_REQ;
                            uhost_req_valid   <= 1'b1;
                            uhost_req_cmd     <= make_cmd(WR_OPC);
                            uhost_req_dstaddr <= base_addr;
                            uhost_req_srcaddr <= host_addr;
                            uhost_req_data    <= make_data(pattern, base_addr);
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                WR_REQ: begin
                    if (req_hs) begin
`ifdef UMI_HOST_AGENT_POSTED_EN
                        // Posted writes stream back-to-back; valid stays high.
                        if (last) begin
                            index             <= '0;
                            state             <= RD_REQ;
                            uhost_req_cmd     <= make_cmd(REQ_RD);
                            uhost_req_dstaddr <= base_q;
                            uhost_req_data    <= '0;
                        end else begin
                            index             <= next_index;
                            uhost_req_dstaddr <= next_addr;
                            uhost_req_data    <= make_data(pat_q, next_addr);
                        end
`else
                        uhost_req_valid  <= 1'b0;
                        uhost_resp_ready <= 1'b1;
                        state            <= WR_RESP;
`endif
                    end
                end
                WR_RESP: begin
                    if (resp_hs) begin
                        uhost_resp_ready <= 1'b0;
                        uhost_req_valid  <= 1'b1;
                        if (err_inc) err_count <= err_count + NW'(1);
                        if (last) begin
                            index             <= '0;
                            state             <= RD_REQ;
                            uhost_req_cmd     <= make_cmd(REQ_RD);
                            uhost_req_dstaddr <= base_q;
                            uhost_req_data    <= '0;
                        end else begin
                            index             <= next_index;
                            state             <= WR_REQ;
                            uhost_req_dstaddr <= next_addr;
                            uhost_req_data    <= make_data(pat_q, next_addr);
                        end
                    end
                end
                RD_REQ: begin
                    if (req_hs) begin
                        uhost_req_valid  <= 1'b0;
                        uhost_resp_ready <= 1'b1;
                        state            <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (resp_hs) begin
                        uhost_resp_ready <= 1'b0;
                        if (err_inc) err_count <= err_count + NW'(1);
                        if (last) begin
                            index <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            index             <= next_index;
                            state             <= RD_REQ;
                            uhost_req_valid   <= 1'b1;
                            uhost_req_dstaddr <= next_addr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_umi_host_agent.sv
// tb/tb_umi_host_agent.sv - directed self-checking bench for umi_host_agent
module tb_umi_host_agent;

    localparam int CW = 32;
    localparam int AW = 64;
    localparam int DW = 256;
    localparam int NW = 16;
`ifdef UMI_HOST_AGENT_POSTED_EN
    localparam logic [4:0] WR_OPC = 5'h05;
`else
    localparam logic [4:0] WR_OPC = 5'h03;
`endif

    logic          clk = 1'b0;
    logic          nreset;
    logic          start;
    logic [NW-1:0] count;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] host_addr;
    logic [63:0]   pattern;
    logic          busy;
    logic          done;
    logic [NW-1:0] err_count;
    logic          uhost_req_valid;
    logic          uhost_req_ready;
    logic [CW-1:0] uhost_req_cmd;
    logic [AW-1:0] uhost_req_dstaddr;
    logic [AW-1:0] uhost_req_srcaddr;
    logic [DW-1:0] uhost_req_data;
    logic          uhost_resp_valid;
    logic          uhost_resp_ready;
    logic [CW-1:0] uhost_resp_cmd;
    logic [AW-1:0] uhost_resp_dstaddr;
    logic [AW-1:0] uhost_resp_srcaddr;
    logic [DW-1:0] uhost_resp_data;

    int checks   = 0;
    int failures = 0;
    logic [63:0] cur_host = 64'h0000_00F0_0000_0040;

    always #5 clk = ~clk;

    umi_host_agent #(.CW(CW), .AW(AW), .DW(DW), .NW(NW)) dut (
        .clk                (clk),
        .nreset             (nreset),
        .start              (start),
        .count              (count),
        .base_addr          (base_addr),
        .host_addr          (host_addr),
        .pattern            (pattern),
        .busy               (busy),
        .done               (done),
        .err_count          (err_count),
        .uhost_req_valid    (uhost_req_valid),
        .uhost_req_ready    (uhost_req_ready),
        .uhost_req_cmd      (uhost_req_cmd),
        .uhost_req_dstaddr  (uhost_req_dstaddr),
        .uhost_req_srcaddr  (uhost_req_srcaddr),
        .uhost_req_data     (uhost_req_data),
        .uhost_resp_valid   (uhost_resp_valid),
        .uhost_resp_ready   (uhost_resp_ready),
        .uhost_resp_cmd     (uhost_resp_cmd),
        .uhost_resp_dstaddr (uhost_resp_dstaddr),
        .uhost_resp_srcaddr (uhost_resp_srcaddr),
        .uhost_resp_data    (uhost_resp_data)
    );

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_cmd(input logic [4:0] opc);
        return {56'h0, 3'd3, opc};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk(64'(busy), 64'd0, {tag, " busy"});
        chk(64'(done), 64'd0, {tag, " done"});
        chk(64'(err_count), 64'd0, {tag, " err_count"});
        chk(64'(uhost_req_valid), 64'd0, {tag, " req_valid"});
        chk(64'(uhost_resp_ready), 64'd0, {tag, " resp_ready"});
        chk(64'(uhost_req_cmd), 64'd0, {tag, " req_cmd"});
        chk(uhost_req_dstaddr, 64'd0, {tag, " req_dstaddr"});
        chk(uhost_req_srcaddr, 64'd0, {tag, " req_srcaddr"});
        chk(64'(uhost_req_data != '0), 64'd0, {tag, " req_data"});
    endtask

    // Holds ready low for a random number of cycles, checking the payload every cycle.
    task automatic serve_req(input logic [4:0] opc, input logic [63:0] addr, input logic [63:0] wdata,
                             input bit stall, input string tag);
        int k;
        k = stall ? int'($urandom_range(0, 3)) : 0;
        for (int s = 0; s <= k; s++) begin
            chk(64'(uhost_req_valid), 64'd1, {tag, " req_valid"});
            chk(64'(uhost_resp_ready), 64'd0, {tag, " resp_ready"});
            chk(64'(uhost_req_cmd), exp_cmd(opc), {tag, " req_cmd"});
            chk(uhost_req_dstaddr, addr, {tag, " req_dstaddr"});
            chk(uhost_req_srcaddr, cur_host, {tag, " req_srcaddr"});
            chk(uhost_req_data[63:0], wdata, {tag, " req_data"});
            chk(64'(uhost_req_data[DW-1:64] != '0), 64'd0, {tag, " req_data_hi"});
            if (s == k) begin
                uhost_resp_valid = 1'b0;
                uhost_req_ready  = 1'b1;
            end else begin
                uhost_resp_valid   = 1'b1;
                uhost_resp_cmd     = 32'h4;
                uhost_resp_dstaddr = cur_host;
            end
            @(negedge clk);
        end
        uhost_req_ready = 1'b0;
    endtask

    task automatic serve_resp(input logic [4:0] opc, input logic [63:0] rdata, input bit stall,
                              input string tag);
        int k;
        k = stall ? int'($urandom_range(0, 3)) : 0;
        for (int s = 0; s < k; s++) begin
            chk(64'(uhost_resp_ready), 64'd1, {tag, " resp_ready_stall"});
            chk(64'(uhost_req_valid), 64'd0, {tag, " req_valid_stall"});
            @(negedge clk);
        end
        chk(64'(uhost_resp_ready), 64'd1, {tag, " resp_ready"});
        chk(64'(uhost_req_valid), 64'd0, {tag, " req_valid_outstanding"});
        uhost_resp_valid   = 1'b1;
        uhost_resp_cmd     = {27'h0, opc};
        uhost_resp_dstaddr = cur_host;
        uhost_resp_srcaddr = 64'h77;
        uhost_resp_data    = {192'h0, rdata};
        @(negedge clk);
        uhost_resp_valid = 1'b0;
        uhost_resp_data  = '0;
    endtask

    task automatic run(input logic [NW-1:0] cnt, input logic [63:0] base, input logic [63:0] pat,
                       input bit stall, input int bad_word, input int rst_word,
                       input logic [NW-1:0] exp_err, input string tag);
        logic [63:0] a;
        start     = 1'b1;
        count     = cnt;
        base_addr = base;
        host_addr = cur_host;
        pattern   = pat;
        @(negedge clk);
        start     = 1'b0;
        count     = '0;
        base_addr = '0;
        host_addr = '0;
        pattern   = '0;
        chk(64'(busy), 64'd1, {tag, " busy_after_start"});
        chk(64'(done), 64'd0, {tag, " done_after_start"});
        chk(64'(err_count), 64'd0, {tag, " err_after_start"});
        if (stall) begin
            start     = 1'b1;
            count     = NW'(9);
            base_addr = 64'hDEAD_0000;
            @(negedge clk);
            start     = 1'b0;
            count     = '0;
            base_addr = '0;
        end
        for (int i = 0; i < int'(cnt); i++) begin
            a = base + 64'(i) * 64'd8;
            serve_req(WR_OPC, a, pat ^ a, stall, $sformatf("%s wr%0d", tag, i));
`ifndef UMI_HOST_AGENT_POSTED_EN
            serve_resp(5'h04, 64'h0, stall, $sformatf("%s wresp%0d", tag, i));
`endif
        end
        for (int i = 0; i < int'(cnt); i++) begin
            a = base + 64'(i) * 64'd8;
            serve_req(5'h01, a, 64'h0, stall, $sformatf("%s rd%0d", tag, i));
            if (i == rst_word) begin
                nreset = 1'b0;
                @(negedge clk);
                chk_all_zero({tag, " midrun_reset"});
                nreset = 1'b1;
                return;
            end
            serve_resp(5'h02, (pat ^ a) ^ ((i == bad_word) ? 64'h100 : 64'h0), stall,
                       $sformatf("%s rresp%0d", tag, i));
        end
        chk(64'(done), 64'd1, {tag, " done"});
        chk(64'(busy), 64'd0, {tag, " busy_end"});
        chk(64'(err_count), 64'(exp_err), {tag, " err_count"});
        chk(64'(uhost_req_valid), 64'd0, {tag, " req_valid_end"});
        chk(64'(uhost_resp_ready), 64'd0, {tag, " resp_ready_end"});
    endtask

    initial begin
        nreset             = 1'b0;
        start              = 1'b0;
        count              = '0;
        base_addr          = '0;
        host_addr          = '0;
        pattern            = '0;
        uhost_req_ready    = 1'b0;
        uhost_resp_valid   = 1'b0;
        uhost_resp_cmd     = '0;
        uhost_resp_dstaddr = '0;
        uhost_resp_srcaddr = '0;
        uhost_resp_data    = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        nreset = 1'b1;
        @(negedge clk);
        chk_all_zero("idle");

        run(NW'(4), 64'h1000, 64'hA5A5_0000_0000_5A5A, 1'b0, -1, -1, NW'(0), "basic");
        run(NW'(4), 64'h1000, 64'hA5A5_0000_0000_5A5A, 1'b1, -1, -1, NW'(0), "stall");
        run(NW'(4), 64'h1000, 64'hA5A5_0000_0000_5A5A, 1'b0, 2, -1, NW'(1), "corrupt");
        run(NW'(4), 64'h1000, 64'hA5A5_0000_0000_5A5A, 1'b0, -1, 1, NW'(0), "reset");
        run(NW'(4), 64'h1000, 64'hA5A5_0000_0000_5A5A, 1'b0, -1, -1, NW'(0), "fresh");
        run(NW'(2), 64'h2000, 64'h0123_4567_89AB_CDEF, 1'b0, -1, -1, NW'(0), "two");
        run(NW'(2), 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_0000_FFFF_0000, 1'b1, -1, -1, NW'(0), "wrap");

        start = 1'b1;
        count = '0;
        @(negedge clk);
        start = 1'b0;
        chk(64'(done), 64'd1, "zero done");
        chk(64'(busy), 64'd0, "zero busy");
        for (int i = 0; i < 3; i++) begin
            chk(64'(uhost_req_valid), 64'd0, "zero req_valid");
            @(negedge clk);
        end
        chk(64'(done), 64'd1, "zero done_held");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
